// File: rtl/vend_pkg.sv
// Shared types and constants for the vending sequencer: state encoding,
// coin values in nickels and the product price lookup.
package vend_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    VEND   = 2'd1,
    CHANGE = 2'd2
  } state_e;

  localparam int NICKEL_V  = 1;
  localparam int DIME_V    = 2;
  localparam int QUARTER_V = 5;

  function automatic int unsigned price_of(input logic [1:0] idx,
                                           input int unsigned p0, input int unsigned p1,
                                           input int unsigned p2, input int unsigned p3);
    case (idx)
      2'd0:    return p0;
      2'd1:    return p1;
      2'd2:    return p2;
      default: return p3;
    endcase
  endfunction

endpackage

// File: rtl/vend_controller_if.sv
// Front-end, dispenser and hopper signals of the vending controller.
// The slave modport is the controller's view, master is the environment's.
interface vend_controller_if #(parameter int CREDIT_W = 6);
  logic                nickle_i, dime_i, quarter_i;
  logic [3:0]          sel_i;
  logic                cancel_i, vend_ack_i, hopper_ack_i;
  logic                vend_req_o;
  logic [1:0]          vend_sel_o;
  logic                hopper_req_o, hopper_dime_o;
  logic [CREDIT_W-1:0] credit_o;
  logic                coin_reject_o, insufficient_o, busy_o, fault_o;

  modport slave (
    input  nickle_i, dime_i, quarter_i, sel_i, cancel_i, vend_ack_i, hopper_ack_i,
    output vend_req_o, vend_sel_o, hopper_req_o, hopper_dime_o, credit_o,
           coin_reject_o, insufficient_o, busy_o, fault_o
  );

  modport master (
    output nickle_i, dime_i, quarter_i, sel_i, cancel_i, vend_ack_i, hopper_ack_i,
    input  vend_req_o, vend_sel_o, hopper_req_o, hopper_dime_o, credit_o,
           coin_reject_o, insufficient_o, busy_o, fault_o
  );
endinterface

// File: rtl/change_sequencer.sv
// Pays out an amount as dime/nickel pulses over the hopper req/ack handshake,
// leaving one request-low cycle between coins.
module change_sequencer #(
  parameter int CW = 6
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          start_i,
  input  logic [CW-1:0] amount_i,
  input  logic          hopper_ack_i,
  output logic          hopper_req_o,
  output logic          hopper_dime_o,
  output logic          done_o,
  output logic [1:0]    dec_o
);

  logic req_q, dime_q, active_q;

  assign dec_o  = (req_q && hopper_ack_i) ? (dime_q ? 2'd2 : 2'd1) : 2'd0;
  // amount_i is the credit still owed, so the last coin is the one that clears it
  assign done_o = req_q && hopper_ack_i && (amount_i == CW'(dec_o));

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      req_q    <= 1'b0;
      dime_q   <= 1'b0;
      active_q <= 1'b0;
    end else if (start_i) begin
      active_q <= 1'b1;
      req_q    <= 1'b1;
      dime_q   <= (amount_i >= CW'(2));
    end else if (req_q) begin
      if (hopper_ack_i) begin
        req_q <= 1'b0;
        if (done_o) active_q <= 1'b0;
      end
    end else if (active_q && amount_i != '0) begin
      req_q  <= 1'b1;
      dime_q <= (amount_i >= CW'(2));
    end
  end

  assign hopper_req_o  = req_q;
  assign hopper_dime_o = dime_q;

endmodule

// File: rtl/vend_controller.sv
// Vending controller: credit accumulation, price check, dispenser handshake
// and change payout. Optional vend-ack timeout under `VEND_TIMEOUT_EN.
module vend_controller
  import vend_pkg::*;
#(
  parameter int CREDIT_W    = 6,
  parameter int MAX_CREDIT  = 20,
  parameter int PRICE0      = 3,
  parameter int PRICE1      = 4,
  parameter int PRICE2      = 5,
  parameter int PRICE3      = 7,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic             clk_i,
  input  logic             rst_i,
  vend_controller_if.slave bus
);

  state_e              state_q;
  logic [CREDIT_W-1:0] credit_q, coin_val, sel_price, vend_price, remain, chg_amt;
  logic [CREDIT_W:0]   coin_sum;
  logic [1:0]          sel_q, sel_idx, coin_cnt, chg_dec;
  logic                vend_req_q, coin_reject_q, insufficient_q, fault_q;
  logic                in_idle, sel_onehot, cancel_ok, sel_ok, sel_afford, coin_any, coin_ok;
  logic                vend_done, vend_to, chg_start, chg_done;

  always_comb begin
    coin_val = '0;
    if (bus.nickle_i)       coin_val = CREDIT_W'(NICKEL_V);
    else if (bus.dime_i)    coin_val = CREDIT_W'(DIME_V);
    else if (bus.quarter_i) coin_val = CREDIT_W'(QUARTER_V);
  end

  always_comb begin
    case (bus.sel_i)
      4'b0010: sel_idx = 2'd1;
      4'b0100: sel_idx = 2'd2;
      4'b1000: sel_idx = 2'd3;
      default: sel_idx = 2'd0;
    endcase
  end

  assign in_idle    = (state_q == IDLE);
  assign coin_cnt   = {1'b0, bus.nickle_i} + {1'b0, bus.dime_i} + {1'b0, bus.quarter_i};
  assign coin_any   = bus.nickle_i | bus.dime_i | bus.quarter_i;
  assign coin_sum   = {1'b0, credit_q} + {1'b0, coin_val};
  assign sel_onehot = (bus.sel_i != 4'd0) && ((bus.sel_i & (bus.sel_i - 4'd1)) == 4'd0);
  assign sel_price  = CREDIT_W'(price_of(sel_idx, PRICE0, PRICE1, PRICE2, PRICE3));
  assign vend_price = CREDIT_W'(price_of(sel_q, PRICE0, PRICE1, PRICE2, PRICE3));
  assign remain     = credit_q - vend_price;

  // Priority in IDLE: cancel, then a one-hot select, then a single coin
  assign cancel_ok  = in_idle && bus.cancel_i && (credit_q != '0);
  assign sel_ok     = in_idle && !cancel_ok && sel_onehot;
  assign sel_afford = (credit_q >= sel_price);
  assign coin_ok    = in_idle && !cancel_ok && !sel_ok && (coin_cnt == 2'd1) &&
                      (coin_sum <= (CREDIT_W+1)'(MAX_CREDIT));

  assign vend_done  = (state_q == VEND) && bus.vend_ack_i;
  assign chg_start  = cancel_ok || (vend_done && remain != '0) || vend_to;
  assign chg_amt    = vend_done ? remain : credit_q;

`ifdef VEND_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  logic [TW-1:0] tcnt_q;
  assign vend_to = (state_q == VEND) && !bus.vend_ack_i && (tcnt_q == TW'(TIMEOUT_CYC - 1));
`else
  logic unused_cfg;
  assign unused_cfg = ^TIMEOUT_CYC;
  assign vend_to    = 1'b0;
`endif

  change_sequencer #(.CW(CREDIT_W)) u_change (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .start_i      (chg_start),
    .amount_i     (chg_amt),
    .hopper_ack_i (bus.hopper_ack_i),
    .hopper_req_o (bus.hopper_req_o),
    .hopper_dime_o(bus.hopper_dime_o),
    .done_o       (chg_done),
    .dec_o        (chg_dec)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q        <= IDLE;
      credit_q       <= '0;
      sel_q          <= '0;
      vend_req_q     <= 1'b0;
      coin_reject_q  <= 1'b0;
      insufficient_q <= 1'b0;
      fault_q        <= 1'b0;
`ifdef VEND_TIMEOUT_EN
      tcnt_q         <= '0;
`endif
    end else begin
      coin_reject_q  <= coin_any && !coin_ok;
      insufficient_q <= sel_ok && !sel_afford;
      fault_q        <= vend_to;
      case (state_q)
        IDLE: begin
          if (cancel_ok) begin
            state_q <= CHANGE;
          end else if (sel_ok && sel_afford) begin
            state_q    <= VEND;
            sel_q      <= sel_idx;
            vend_req_q <= 1'b1;
`ifdef VEND_TIMEOUT_EN
            tcnt_q     <= '0;
`endif
          end else if (coin_ok) begin
            credit_q <= coin_sum[CREDIT_W-1:0];
          end
        end
        VEND: begin
          if (vend_done) begin
            vend_req_q <= 1'b0;
            credit_q   <= remain;
            state_q    <= (remain != '0) ? CHANGE : IDLE;
          end else if (vend_to) begin
            // no deduction: the whole credit is refunded
            vend_req_q <= 1'b0;
            state_q    <= CHANGE;
          end
`ifdef VEND_TIMEOUT_EN
          tcnt_q <= tcnt_q + TW'(1);
`endif
        end
        CHANGE: begin
          credit_q <= credit_q - CREDIT_W'(chg_dec);
          if (chg_done) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.vend_req_o     = vend_req_q;
  assign bus.vend_sel_o     = sel_q;
  assign bus.credit_o       = credit_q;
  assign bus.coin_reject_o  = coin_reject_q;
  assign bus.insufficient_o = insufficient_q;
  assign bus.busy_o         = !in_idle;
  assign bus.fault_o        = fault_q;

endmodule
